// File: rtl/bbs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bbs_pkg
//  Description : Shared constants for the BBS forward generator and the
//                reverse stepper: state width, Blum modulus, principal-root
//                exponent and the reverse-stepper FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package bbs_pkg;

    localparam int                     SIZE     = 16;
    localparam logic [SIZE-1:0]        MOD      = 16'd40633;   // 179 * 227
    localparam int                     EXP_BITS = 13;
    localparam logic [EXP_BITS-1:0]    EXP      = 13'd5029;    // ((p-1)(q-1)+4)/8
    localparam int                     K_W      = $clog2(EXP_BITS);

    // Reverse-stepper FSM encoding
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_SQR  = 3'd2;
    localparam logic [2:0] S_MUL  = 3'd3;
    localparam logic [2:0] S_CHK  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

endpackage
`default_nettype wire

// File: rtl/bbs_modmul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bbs_modmul_seq
//  Description : Sequential modular multiplier, p = a*b mod MOD. One issue
//                cycle loads the operands, then SIZE left-to-right shift-add
//                iterations (multiplier MSB first). done is high during the
//                last iteration cycle and p carries the final product then.
//                Operands must be < MOD; the result is always < MOD.
//  Revision    : 1.0 - initial release
// ============================================================================
module bbs_modmul_seq
    import bbs_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [SIZE-1:0] p
);

    localparam int               CNT_W   = $clog2(SIZE + 1);
    localparam logic [SIZE+1:0]  MOD_EXT = {2'b00, MOD};

    logic [SIZE-1:0]  r_a;
    logic [SIZE-1:0]  r_b;
    logic [SIZE-1:0]  r_r;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;

    logic [SIZE+1:0]  w_dbl;
    logic [SIZE+1:0]  w_dbl_red;
    logic [SIZE+1:0]  w_sum;
    logic [SIZE+1:0]  w_sum_red;
    logic [SIZE-1:0]  w_r_next;
    logic [1:0]       w_unused_hi;

    // One shift-add step: r = 2r mod MOD, then r = r + (b_msb ? a : 0) mod MOD
    always_comb begin
        w_dbl     = {1'b0, r_r, 1'b0};
        w_dbl_red = (w_dbl >= MOD_EXT) ? (w_dbl - MOD_EXT) : w_dbl;
        w_sum     = w_dbl_red + (r_b[SIZE-1] ? {2'b00, r_a} : '0);
        w_sum_red = (w_sum >= MOD_EXT) ? (w_sum - MOD_EXT) : w_sum;
    end

    assign {w_unused_hi, w_r_next} = w_sum_red;

    assign busy = r_busy;
    assign done = r_busy && (r_cnt == CNT_W'(1));
    assign p    = w_r_next;

    // Operand load on start, then one iteration per cycle until the count expires
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a    <= '0;
            r_b    <= '0;
            r_r    <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (start && !r_busy) begin
            r_a    <= a;
            r_b    <= b;
            r_r    <= '0;
            r_cnt  <= CNT_W'(SIZE);
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_r   <= w_r_next;
            r_b   <= {r_b[SIZE-2:0], 1'b0};
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bbs_reverse_stepper.sv
`default_nettype none
// ============================================================================
//  Module      : bbs_reverse_stepper
//  Description : Inverse BBS step. Computes the principal square root
//                x(i-1) = x(i)^EXP mod MOD by square-and-multiply over EXP
//                (MSB already consumed by loading acc = x), then squares the
//                root once more to confirm it maps back to the input.
//                Fixed 325-cycle latency; out-of-range inputs take 2 cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module bbs_reverse_stepper
    import bbs_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] in_state,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] out_state,
    output logic            out_lsb,
    output logic            out_ok,
    output logic            out_err
);

    localparam logic [K_W-1:0] K_INIT = K_W'(EXP_BITS - 2);

    logic [2:0]      r_state;
    logic [SIZE-1:0] r_acc;
    logic [SIZE-1:0] r_base;
    logic [K_W-1:0]  r_k;
    logic            r_out_valid;
    logic [SIZE-1:0] r_out_state;
    logic            r_out_ok;
    logic            r_out_err;

    logic            w_in_err;
    logic            w_mul_start;
    logic [SIZE-1:0] w_mul_b;
    logic            w_mul_busy;
    logic            w_mul_done;
    logic [SIZE-1:0] w_mul_p;

    assign w_in_err    = (r_base == '0) || (r_base >= MOD);
    assign w_mul_start = ((r_state == S_SQR) || (r_state == S_MUL) || (r_state == S_CHK))
                         && !w_mul_busy;
    // Squaring and the final check use acc for both operands; MUL uses the input
    assign w_mul_b     = (r_state == S_MUL) ? r_base : r_acc;

    bbs_modmul_seq u_modmul (
        .clk   (clk),
        .reset (reset),
        .start (w_mul_start),
        .a     (r_acc),
        .b     (w_mul_b),
        .busy  (w_mul_busy),
        .done  (w_mul_done),
        .p     (w_mul_p)
    );

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign out_state = r_out_state;
    assign out_lsb   = r_out_state[0];
    assign out_ok    = r_out_ok;
    assign out_err   = r_out_err;

    // Control FSM: accept, walk the exponent bits, verify, then hold the result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_base      <= '0;
            r_k         <= '0;
            r_out_valid <= 1'b0;
            r_out_state <= '0;
            r_out_ok    <= 1'b0;
            r_out_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_base  <= in_state;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_in_err) begin
                        r_out_state <= '0;
                        r_out_ok    <= 1'b0;
                        r_out_err   <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_acc   <= r_base;
                        r_k     <= K_INIT;
                        r_state <= S_SQR;
                    end
                end
                S_SQR: begin
                    if (w_mul_done) begin
                        r_acc <= w_mul_p;
                        if (EXP[r_k]) begin
                            r_state <= S_MUL;
                        end else if (r_k == '0) begin
                            r_state <= S_CHK;
                        end else begin
                            r_k <= r_k - K_W'(1);
                        end
                    end
                end
                S_MUL: begin
                    if (w_mul_done) begin
                        r_acc <= w_mul_p;
                        if (r_k == '0) begin
                            r_state <= S_CHK;
                        end else begin
                            r_k     <= r_k - K_W'(1);
                            r_state <= S_SQR;
                        end
                    end
                end
                S_CHK: begin
                    if (w_mul_done) begin
                        r_out_state <= r_acc;
                        r_out_ok    <= (w_mul_p == r_base);
                        r_out_err   <= 1'b0;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    // out_valid rises one cycle after entry; leave only on handshake
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bbs_reverse_stepper.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_bbs_reverse_stepper
//  Description : Self-checking bench for bbs_reverse_stepper. A modular
//                exponentiation model predicts every result; directed cases
//                pin known roots, latencies, backpressure and reset abort.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bbs_reverse_stepper;

    localparam longint unsigned M       = 40633;
    localparam longint unsigned E       = 5029;
    localparam int              LAT     = 325;
    localparam int              LAT_ERR = 2;

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic        in_valid  = 1'b0;
    logic [15:0] in_state  = '0;
    logic        out_ready = 1'b1;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_state;
    logic        out_lsb;
    logic        out_ok;
    logic        out_err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Expected result of the transaction in flight
    logic        txn_active = 1'b0;
    logic        txn_seen   = 1'b0;
    logic [15:0] exp_state  = '0;
    logic        exp_ok     = 1'b0;
    logic        exp_err    = 1'b0;
    int          acc_cyc    = 0;

    // Outputs captured on the first valid cycle of the last transaction
    logic [15:0] cap_state;
    logic        cap_lsb, cap_ok, cap_err;
    int          cap_lat;

    bbs_reverse_stepper dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .out_lsb   (out_lsb),
        .out_ok    (out_ok),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint unsigned modpow(input longint unsigned x, input longint unsigned e);
        longint unsigned r = 1;
        longint unsigned b = x % M;
        longint unsigned k = e;
        while (k != 0) begin
            if (k[0]) r = (r * b) % M;
            b = (b * b) % M;
            k = k >> 1;
        end
        return r;
    endfunction

    // Reference: principal root via x^E, verified by squaring back
    task automatic model_set(input logic [15:0] x);
        longint unsigned root;
        if (x == 16'd0 || longint'(x) >= M) begin
            exp_err   = 1'b1;
            exp_state = '0;
            exp_ok    = 1'b0;
        end else begin
            root      = modpow(longint'(x), E);
            exp_err   = 1'b0;
            exp_state = 16'(root);
            exp_ok    = ((root * root) % M) == longint'(x);
        end
    endtask

    // Compare process: every valid output cycle is checked against the model
    always @(negedge clk) begin
        if (reset && out_valid) begin
            if (!txn_active) begin
                check("spurious_out_valid", 1, 0);
            end else begin
                if (!txn_seen) begin
                    check("latency", cyc - acc_cyc, exp_err ? LAT_ERR : LAT);
                    txn_seen = 1'b1;
                end
                check("out_state", out_state, exp_state);
                check("out_lsb", out_lsb, exp_state[0]);
                check("out_ok", out_ok, exp_ok);
                check("out_err", out_err, exp_err);
                check("in_ready_while_valid", in_ready, 0);
            end
        end
    end

    // Offer x, wait for acceptance; sets acc_cyc to the accepting edge count
    task automatic send(input logic [15:0] x, output logic ok);
        int n;
        model_set(x);
        @(negedge clk); #1;
        in_state = x;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 2000) begin
            @(negedge clk); #1;
            n++;
        end
        ok = in_ready;
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
        end else begin
            acc_cyc    = cyc + 1;
            txn_seen   = 1'b0;
            txn_active = 1'b1;
            @(negedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    // Full transaction; hold = cycles of out_ready=0 after out_valid rises
    task automatic run(input logic [15:0] x, input int hold);
        int   n;
        logic ok;
        out_ready = (hold == 0);
        send(x, ok);
        if (ok) begin
            n = 0;
            while (!out_valid && n < 1000) begin
                @(negedge clk); #1;
                n++;
            end
            if (!out_valid) begin
                check("result_timeout", 0, 1);
                txn_active = 1'b0;
            end else begin
                cap_state = out_state;
                cap_lsb   = out_lsb;
                cap_ok    = out_ok;
                cap_err   = out_err;
                cap_lat   = cyc - acc_cyc;
                for (int i = 0; i < hold; i++) begin
                    @(negedge clk); #1;
                    check("hold_state", out_state, cap_state);
                    check("hold_valid", out_valid, 1);
                    check("hold_in_ready", in_ready, 0);
                end
                out_ready = 1'b1;
                @(negedge clk); #1;
                check("valid_drop_after_accept", out_valid, 0);
                check("in_ready_after_accept", in_ready, 1);
                txn_active = 1'b0;
            end
        end
        out_ready = 1'b1;
    endtask

    initial begin
        logic            ok;
        longint unsigned s, y1, y2;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_state", out_state, 0);
        check("rst_out_lsb", out_lsb, 0);
        check("rst_out_ok", out_ok, 0);
        check("rst_out_err", out_err, 0);
        reset = 1'b1;
        @(negedge clk); #1;
        check("post_rst_in_ready", in_ready, 1);

        // Known roots
        run(16'd9, 0);
        check("r9_state", cap_state, 3);
        check("r9_lsb", cap_lsb, 1);
        check("r9_ok", cap_ok, 1);
        check("r9_err", cap_err, 0);
        check("r9_latency", cap_lat, 325);

        run(16'd1, 0);
        check("r1_state", cap_state, 1);
        check("r1_ok", cap_ok, 1);

        // Out-of-range inputs
        run(16'd0, 0);
        check("r0_err", cap_err, 1);
        check("r0_state", cap_state, 0);
        check("r0_ok", cap_ok, 0);
        check("r0_latency", cap_lat, 2);
        run(16'd40633, 0);
        check("rmod_err", cap_err, 1);
        check("rmod_state", cap_state, 0);
        check("rmod_ok", cap_ok, 0);
        check("rmod_latency", cap_lat, 2);

        // -1 is a non-residue: full latency, no root
        run(16'd40632, 0);
        check("rneg1_ok", cap_ok, 0);
        check("rneg1_err", cap_err, 0);
        check("rneg1_latency", cap_lat, 325);

        // Backpressure
        run(16'd4, 50);
        check("bp_latency", cap_lat, 325);

        // Chained rewind 81 -> 9 -> 3
        run(16'd81, 0);
        check("r81_state", cap_state, 9);
        check("r81_ok", cap_ok, 1);
        run(cap_state, 0);
        check("chain_state", cap_state, 3);
        check("chain_ok", cap_ok, 1);

        // Reset 100 cycles into an operation
        send(16'd81, ok);
        if (ok) begin
            while (cyc < acc_cyc + 100) @(negedge clk);
            #1;
            reset = 1'b0;
            #1;
            txn_active = 1'b0;
            check("abort_in_ready", in_ready, 1);
            check("abort_out_valid", out_valid, 0);
            check("abort_out_state", out_state, 0);
            check("abort_out_lsb", out_lsb, 0);
            check("abort_out_ok", out_ok, 0);
            check("abort_out_err", out_err, 0);
            repeat (2) @(negedge clk);
            #1;
            reset = 1'b1;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk); #1;
                check("abort_no_output", out_valid, 0);
                check("abort_idle", in_ready, 1);
            end
        end

        // Random inputs over the whole 16-bit range
        for (int i = 0; i < 20; i++) begin
            run(16'($urandom), 0);
        end

        // Round trip: two forward steps, one step back
        for (int i = 0; i < 120; i++) begin
            s = longint'($urandom_range(1, 40632));
            while ((s % 179) == 0 || (s % 227) == 0) s = longint'($urandom_range(1, 40632));
            y1 = (s * s) % M;
            y2 = (y1 * y1) % M;
            run(16'(y2), 0);
            check("roundtrip_state", cap_state, longint'(y1));
            check("roundtrip_ok", cap_ok, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
